pipe_stage_reg: RTL and testbench

Generic, parametrised pipeline stage register that replaces the fixed per-field stage registers between pipeline stages. It carries one data bus and one control bus with a valid/ready handshake and a two-entry skid buffer, so a stage can stall without a combinational ready path. It supports flush, which inserts a bubble with zeroed control, and exposes occupancy and a saturating bubble counter for performance debug. It is instantiated once per stage boundary: IF/ID, ID/EX, EX/MEM and MEM/WB.

---
 rtl/pipe_stage_reg.sv | 117 +++++++++++
 tb/tb_pipe_stage_reg.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with a valid/ready handshake and a two-entry skid buffer.
// Flush drops every held entry and leaves a zero-control bubble; a saturating counter tracks idle output cycles.
module pipe_stage_reg #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt,
  input  logic              cnt_clr
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] main_data, main_data_nxt, skid_data, skid_data_nxt;
  logic [CTRL_W-1:0] main_ctrl, main_ctrl_nxt, skid_ctrl, skid_ctrl_nxt;
  logic              accept, take;

  // in_ready depends only on registered state, so a downstream stall never ripples upstream combinationally.
  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign out_data  = main_data;
  assign out_ctrl  = out_valid ? main_ctrl : '0;
  assign occupancy = state;
  assign accept    = in_valid & in_ready;
  assign take      = out_valid & out_ready;

  always_comb begin
    state_nxt     = state;
    main_data_nxt = main_data;
    main_ctrl_nxt = main_ctrl;
    skid_data_nxt = skid_data;
    skid_ctrl_nxt = skid_ctrl;
    if (flush) begin
      state_nxt     = EMPTY;
      main_data_nxt = '0;
      main_ctrl_nxt = '0;
      skid_data_nxt = '0;
      skid_ctrl_nxt = '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt     = ONE;
            main_data_nxt = in_data;
            main_ctrl_nxt = in_ctrl;
          end
        end
        ONE: begin
          if (accept && take) begin
            main_data_nxt = in_data;
            main_ctrl_nxt = in_ctrl;
          end else if (accept) begin
            state_nxt     = TWO;
            skid_data_nxt = in_data;
            skid_ctrl_nxt = in_ctrl;
          end else if (take) begin
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          // The skid entry moves to the head; its old copy is never presented again.
          if (take) begin
            state_nxt     = ONE;
            main_data_nxt = skid_data;
            main_ctrl_nxt = skid_ctrl;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= EMPTY;
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else begin
      state     <= state_nxt;
      main_data <= main_data_nxt;
      main_ctrl <= main_ctrl_nxt;
      skid_data <= skid_data_nxt;
      skid_ctrl <= skid_ctrl_nxt;
    end
  end

  // Clear wins over increment; flush intentionally leaves the count alone.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bubble_cnt <= '0;
    end else if (cnt_clr) begin
      bubble_cnt <= '0;
    end else if (!out_valid && (bubble_cnt != '1)) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg: vector table for streaming/stall/flush,
// hand sequences for reset, counter saturation/clear and mid-transfer reset.
module tb_pipe_stage_reg;

  localparam int DATA_W = 64;
  localparam int CTRL_W = 16;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  bubble_cnt;
  logic              cnt_clr;

  int tests_run;
  int tests_failed;

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_ctrl    (in_ctrl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ctrl   (out_ctrl),
    .occupancy  (occupancy),
    .bubble_cnt (bubble_cnt),
    .cnt_clr    (cnt_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              iv;
    logic [DATA_W-1:0] d;
    logic [CTRL_W-1:0] c;
    logic              ordy;
    logic              fl;
    logic              exp_rdy;
    logic              exp_ov;
    logic [DATA_W-1:0] exp_d;
    logic [CTRL_W-1:0] exp_c;
    logic [1:0]        exp_occ;
    logic              chk_d;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(input logic iv, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                              input logic ordy, input logic fl, input logic exp_rdy, input logic exp_ov,
                              input logic [DATA_W-1:0] exp_d, input logic [CTRL_W-1:0] exp_c,
                              input logic [1:0] exp_occ, input logic chk_d);
    vec_t v;
    v.iv = iv; v.d = d; v.c = c; v.ordy = ordy; v.fl = fl;
    v.exp_rdy = exp_rdy; v.exp_ov = exp_ov; v.exp_d = exp_d; v.exp_c = exp_c;
    v.exp_occ = exp_occ; v.chk_d = chk_d;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    in_valid  = v.iv;
    in_data   = v.d;
    in_ctrl   = v.c;
    out_ready = v.ordy;
    flush     = v.fl;
    step();
  endtask

  task automatic idle();
    in_valid = 1'b0; in_data = 'x; in_ctrl = 'x; flush = 1'b0; cnt_clr = 1'b0;
  endtask

  initial begin
    logic [DATA_W-1:0] xd;
    logic [CTRL_W-1:0] xc;
    tests_run    = 0;
    tests_failed = 0;
    xd = 'x;
    xc = 'x;

    // streaming 1..8, then drain
    for (int i = 0; i < 8; i++)
      vecs[i] = mk(1, DATA_W'(i + 1), 16'hFFFF, 1, 0, 1, 1, DATA_W'(i + 1), 16'hFFFF, 2'd1, 1);
    vecs[8]  = mk(0, xd, xc, 1, 0, 1, 0, '0, 16'h0000, 2'd0, 0);
    // stall with skid: A, B held, C waits upstream
    vecs[9]  = mk(1, 64'hA, 16'h0A0A, 0, 0, 1, 1, 64'hA, 16'h0A0A, 2'd1, 1);
    vecs[10] = mk(1, 64'hB, 16'h0B0B, 0, 0, 0, 1, 64'hA, 16'h0A0A, 2'd2, 1);
    vecs[11] = mk(1, 64'hC, 16'h0C0C, 0, 0, 0, 1, 64'hA, 16'h0A0A, 2'd2, 1);
    vecs[12] = mk(1, 64'hC, 16'h0C0C, 1, 0, 1, 1, 64'hB, 16'h0B0B, 2'd1, 1);
    vecs[13] = mk(1, 64'hC, 16'h0C0C, 1, 0, 1, 1, 64'hC, 16'h0C0C, 2'd1, 1);
    vecs[14] = mk(0, xd, xc, 1, 0, 1, 0, '0, 16'h0000, 2'd0, 0);
    // flush while full, D offered in the same cycle and lost
    vecs[15] = mk(1, 64'hA, 16'h0A0A, 0, 0, 1, 1, 64'hA, 16'h0A0A, 2'd1, 1);
    vecs[16] = mk(1, 64'hB, 16'h0B0B, 0, 0, 0, 1, 64'hA, 16'h0A0A, 2'd2, 1);
    vecs[17] = mk(1, 64'hD, 16'h0D0D, 1, 1, 1, 0, '0, 16'h0000, 2'd0, 1);
    vecs[18] = mk(0, xd, xc, 1, 0, 1, 0, '0, 16'h0000, 2'd0, 1);

    rst = 1'b0; flush = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
    in_valid = 1'b1; in_data = 64'h1234; in_ctrl = 16'hFFFF;

    // reset held two cycles with traffic offered
    for (int i = 0; i < 2; i++) begin
      step();
      checkOutput("rst_in_ready",  64'(in_ready),   64'd1);
      checkOutput("rst_out_valid", 64'(out_valid),  64'd0);
      checkOutput("rst_out_data",  64'(out_data),   64'd0);
      checkOutput("rst_out_ctrl",  64'(out_ctrl),   64'd0);
      checkOutput("rst_occupancy", 64'(occupancy),  64'd0);
      checkOutput("rst_bubble",    64'(bubble_cnt), 64'd0);
    end

    rst = 1'b1;
    idle();
    step();
    checkOutput("bubble_first_idle", 64'(bubble_cnt), 64'd1);

    // 14 more idle cycles reach 15, then it must stay there
    for (int i = 0; i < 14; i++) step();
    checkOutput("bubble_at_15", 64'(bubble_cnt), 64'd15);
    for (int i = 0; i < 5; i++) step();
    checkOutput("bubble_saturated", 64'(bubble_cnt), 64'd15);

    cnt_clr = 1'b1;
    step();
    checkOutput("bubble_clr_priority", 64'(bubble_cnt), 64'd0);
    cnt_clr = 1'b0;
    step();
    checkOutput("bubble_after_clr", 64'(bubble_cnt), 64'd1);
    flush = 1'b1;
    step();
    checkOutput("bubble_flush_keeps", 64'(bubble_cnt), 64'd2);
    flush = 1'b0;

    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d_in_ready", i),  64'(in_ready),  64'(vecs[i].exp_rdy));
      checkOutput($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].exp_ov));
      checkOutput($sformatf("v%0d_out_ctrl", i),  64'(out_ctrl),  64'(vecs[i].exp_c));
      checkOutput($sformatf("v%0d_occupancy", i), 64'(occupancy), 64'(vecs[i].exp_occ));
      if (vecs[i].chk_d)
        checkOutput($sformatf("v%0d_out_data", i), out_data, vecs[i].exp_d);
    end

    // mid-transfer reset with both entries held
    idle();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'hA; in_ctrl = 16'h0A0A;
    step();
    in_data = 64'hB; in_ctrl = 16'h0B0B;
    step();
    checkOutput("mid_occ_full", 64'(occupancy), 64'd2);
    in_valid = 1'b0; in_data = 'x; in_ctrl = 'x;
    out_ready = 1'b1;
    rst = 1'b0;
    step();
    checkOutput("mid_rst_occ",       64'(occupancy),  64'd0);
    checkOutput("mid_rst_out_valid", 64'(out_valid),  64'd0);
    checkOutput("mid_rst_in_ready",  64'(in_ready),   64'd1);
    checkOutput("mid_rst_out_data",  64'(out_data),   64'd0);
    checkOutput("mid_rst_bubble",    64'(bubble_cnt), 64'd0);
    rst = 1'b1;
    step();
    checkOutput("post_rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("post_rst_out_ctrl",  64'(out_ctrl),  64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
